// File: rtl/msdap_out_collector.sv
// Capture stage for the MSDAP serial outputs: deserialises framed MSB-first
// L/R words and queues completed pairs in a small valid/ready FIFO.
module msdap_out_collector #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Sclk,
    input  logic                     Reset_n,
    input  logic                     Frame,
    input  logic                     OutReady,
    input  logic                     OutputL,
    input  logic                     OutputR,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_dataL,
    output logic [WIDTH-1:0]         rd_dataR,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               frame_err_cnt,
    output logic [15:0]              words_captured
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-2:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_l_q [DEPTH];
    logic [WIDTH-1:0] mem_r_q [DEPTH];
    logic             ovf_q, ovf_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      wc_q, wc_d;

    logic             word_done, abort, full, empty, do_push, do_pop;
    logic [WIDTH-1:0] word_l, word_r;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_l_d    = sh_l_q;
        sh_r_d    = sh_r_q;
        word_done = 1'b0;
        abort     = 1'b0;
        word_l    = {sh_l_q, OutputL};
        word_r    = {sh_r_q, OutputR};

        unique case (state_q)
            IDLE: begin
                if (Frame && OutReady) begin
                    state_d = SHIFT;
                    cnt_d   = 6'(WIDTH - 2);
                    sh_l_d  = {{(WIDTH-2){1'b0}}, OutputL};
                    sh_r_d  = {{(WIDTH-2){1'b0}}, OutputR};
                end
            end
            SHIFT: begin
                // Priority: OutReady loss aborts, then Frame resyncs, then completion.
                if (!OutReady) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (Frame) begin
                    abort  = 1'b1;
                    cnt_d  = 6'(WIDTH - 2);
                    sh_l_d = {{(WIDTH-2){1'b0}}, OutputL};
                    sh_r_d = {{(WIDTH-2){1'b0}}, OutputR};
                end else if (cnt_q == 6'd0) begin
                    word_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d  = cnt_q - 6'd1;
                    sh_l_d = {sh_l_q[WIDTH-3:0], OutputL};
                    sh_r_d = {sh_r_q[WIDTH-3:0], OutputR};
                end
            end
        endcase
    end

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = !empty && rd_ready;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
        do_push = word_done && (!full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | (word_done && full && !do_pop);
        err_d    = (abort && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        wc_d     = do_push ? wc_q + 16'd1 : wc_q;
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_l_q   <= '0;
            sh_r_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= '0;
            wc_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_l_q[i] <= '0;
                mem_r_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            wc_q     <= wc_d;
            if (do_push) begin
                mem_l_q[wr_ptr_q[AW-1:0]] <= word_l;
                mem_r_q[wr_ptr_q[AW-1:0]] <= word_r;
            end
        end
    end

    assign rd_valid       = !empty;
    assign rd_dataL       = mem_l_q[rd_ptr_q[AW-1:0]];
    assign rd_dataR       = mem_r_q[rd_ptr_q[AW-1:0]];
    assign fifo_count     = wr_ptr_q - rd_ptr_q;
    assign overflow       = ovf_q;
    assign frame_err_cnt  = err_q;
    assign words_captured = wc_q;

endmodule
